// File: rtl/psp_mem_pkg.sv
// Shared types for the PSP memory responder: FSM states, the MMIO LED address
// and the byte-lane merge used by the backing RAM.
package psp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EXEC,
        RESP
    } state_t;

    localparam logic [31:0] MMIO_LED_ADDR = 32'hFFFF_FFF0;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/psp_mem_ram.sv
// Synchronous single-port word RAM with byte-lane write enables and a
// registered (1-cycle) read port that samples every cycle.
module psp_mem_ram
    import psp_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wmask,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage arrays carry no reset; clearing them would force flops
    // instead of RAM macros, and their contents are undefined until written.
    always_ff @(posedge clk) begin
        if (|wmask) mem[addr] <= merge_lanes(mem[addr], wdata, wmask);
        rdata <= mem[addr];
    end

endmodule

// File: rtl/psp_mem_responder.sv
// Responder end of the core memory port: one request at a time, programmable
// wait states, RAM backing. Optional MMIO LED register via PSP_MEM_MMIO_LED_EN.
module psp_mem_responder
    import psp_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [3:0]        led
);

    localparam int RAM_AW = $clog2(DEPTH_WORDS);
    localparam int IDX_W  = ADDR_W - 2;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [3:0]          lat_wmask;

    logic [IDX_W-1:0]    lat_idx;
    logic                misaligned;
    logic                in_range;
    logic                is_mmio;
    logic                ram_ok;
    logic                req_err;
    logic [RAM_AW-1:0]   ram_addr;
    logic [3:0]          ram_be;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   exec_rdata;
    logic [3:0]          led_q;

    assign lat_idx    = lat_addr[ADDR_W-1:2];
    assign misaligned = |lat_addr[1:0];
    assign in_range   = lat_idx < IDX_W'(DEPTH_WORDS);
    assign ram_ok     = !misaligned && in_range;
    assign req_err    = !ram_ok && !is_mmio;

    // Reads are side-effect free, so the RAM samples the live bus address while
    // idle; the word is therefore ready in EXEC even with zero wait states.
    assign ram_addr = (state == IDLE) ? req_addr[RAM_AW+1:2] : lat_addr[RAM_AW+1:2];
    assign ram_be   = (state == EXEC && lat_write && ram_ok) ? lat_wmask : 4'b0000;

    psp_mem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (RAM_AW)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .wdata(lat_wdata),
        .wmask(ram_be),
        .rdata(ram_rdata)
    );

    // NOTE: combinational blocks assign every output a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        exec_rdata = '0;
        if (!lat_write) begin
            if (ram_ok)       exec_rdata = ram_rdata;
            else if (is_mmio) exec_rdata = DATA_W'(led_q);
        end
    end

`ifdef PSP_MEM_MMIO_LED_EN
    assign is_mmio = (lat_addr == ADDR_W'(MMIO_LED_ADDR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= 4'b0000;
        end else if (state == EXEC && lat_write && is_mmio && lat_wmask[0]) begin
            led_q <= lat_wdata[3:0];
        end
    end
`else
    assign is_mmio = 1'b0;
    assign led_q   = 4'b0000;
`endif

    assign led = led_q;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= 4'b0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wmask <= req_wmask;
                        req_ready <= 1'b0;
                        wait_cnt  <= 4'd0;
                        state     <= (WAIT_STATES > 0) ? WAIT : EXEC;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                        wait_cnt <= 4'd0;
                        state    <= EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                EXEC: begin
                    resp_valid <= 1'b1;
                    resp_err   <= req_err;
                    resp_rdata <= exec_rdata;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psp_mem_responder.sv
// Self-checking bench for psp_mem_responder: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_psp_mem_responder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int WS     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_wmask = 4'h0;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [3:0]        led;

    psp_mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .led       (led)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int bp_mode = 0;

    // Transaction-level model: busy flag, cycles left until the response shows,
    // the expected response, and the write that lands when execution happens.
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] exp_rdata = '0;
    bit          exp_err = 1'b0;
    bit          exp_known = 1'b0;
    bit          pend_mem = 1'b0;
    int          pend_idx = 0;
    logic [31:0] pend_data = '0;
    logic [3:0]  pend_mask = '0;
    bit          pend_led = 1'b0;
    logic [3:0]  pend_led_val = '0;
    logic [3:0]  led_m = '0;
    logic [31:0] mem [int];

    int          cyc = 0;
    int          acc_cyc = 0;
    int          hs_cyc = 0;
    int          first_valid_cyc = 0;
    bit          seen_valid = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no DUT event within budget (cycle %0d)", name, cyc);
    endtask

    // Compare process: checks outputs each cycle, then advances the model by
    // the handshakes that the coming rising edge will perform.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                busy     = 1'b0;
                pend_mem = 1'b0;
                pend_led = 1'b0;
                led_m    = 4'h0;
                check("rst_req_ready", 32'(req_ready), 32'd1);
                check("rst_resp_valid", 32'(resp_valid), 32'd0);
                check("rst_resp_rdata", resp_rdata, 32'd0);
                check("rst_resp_err", 32'(resp_err), 32'd0);
                check("rst_led", 32'(led), 32'd0);
            end else begin
                check("req_ready", 32'(req_ready), 32'(!busy));
                check("resp_valid", 32'(resp_valid), 32'(busy && cnt == 0));
                check("led", 32'(led), 32'(led_m));
                if (busy && cnt == 0) begin
                    check("resp_err", 32'(resp_err), 32'(exp_err));
                    if (exp_known) check("resp_rdata", resp_rdata, exp_rdata);
                    if (!seen_valid) first_valid_cyc = cyc;
                    seen_valid = 1'b1;
                end
                if (!busy) begin
                    if (req_valid) begin
                        bit mis, mmio, inr, err;
                        int widx;
                        widx = int'(req_addr >> 2);
                        mis  = (req_addr % 4) != 0;
                        inr  = (req_addr >> 2) < DEPTH;
`ifdef PSP_MEM_MMIO_LED_EN
                        mmio = (req_addr == 32'hFFFF_FFF0);
`else
                        mmio = 1'b0;
`endif
                        err = mis || (!inr && !mmio);
                        exp_err   = err;
                        exp_known = 1'b1;
                        exp_rdata = '0;
                        if (req_write) begin
                            if (!err && mmio && req_wmask[0]) begin
                                pend_led     = 1'b1;
                                pend_led_val = req_wdata[3:0];
                            end else if (!err && !mmio) begin
                                pend_mem  = 1'b1;
                                pend_idx  = widx;
                                pend_data = req_wdata;
                                pend_mask = req_wmask;
                            end
                        end else if (!err) begin
                            if (mmio) exp_rdata = {28'h0, led_m};
                            else if (mem.exists(widx)) exp_rdata = mem[widx];
                            else exp_known = 1'b0;
                        end
                        busy       = 1'b1;
                        cnt        = WS + 1;
                        acc_cyc    = cyc;
                        seen_valid = 1'b0;
                    end
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (pend_mem && (pend_mask == 4'hF || mem.exists(pend_idx))) begin
                            logic [31:0] w;
                            w = mem.exists(pend_idx) ? mem[pend_idx] : 32'h0;
                            for (int b = 0; b < 4; b++)
                                if (pend_mask[b]) w[8*b +: 8] = pend_data[8*b +: 8];
                            mem[pend_idx] = w;
                        end
                        if (pend_led) led_m = pend_led_val;
                        pend_mem = 1'b0;
                        pend_led = 1'b0;
                    end
                end else if (resp_ready) begin
                    busy       = 1'b0;
                    hs_cyc     = cyc;
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                end
            end
        end
    end

    // Response-side driver: always ready, stalled, or random backpressure.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'b0;
                default: resp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 500) begin
                timeout("req_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!busy) break;
            n++;
            if (n > 500) begin
                timeout("resp_handshake");
                break;
            end
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid) break;
            n++;
            if (n > 100) begin
                timeout("resp_valid_rise");
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then a read of word 0: response in the 4th cycle after accept.
        check("t1_ready_after_reset", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        wait_idle();
        check("t1_latency", first_valid_cyc - acc_cyc, 32'd4);
        check("t1_err", 32'(last_err), 32'd0);

        // Byte-lane merge.
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        do_req(1'b1, 32'h10, 32'h0000_00AA, 4'h1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        wait_idle();
        check("t2_merge_rdata", last_rdata, 32'hDEAD_BEAA);
        check("t2_err", 32'(last_err), 32'd0);

        // Misaligned and out-of-range reads.
        do_req(1'b0, 32'h13, 32'h0, 4'hF);
        wait_idle();
        check("t3_misaligned_err", 32'(last_err), 32'd1);
        check("t3_misaligned_rdata", last_rdata, 32'd0);
        do_req(1'b0, DEPTH * 4, 32'h0, 4'hF);
        wait_idle();
        check("t3_range_err", 32'(last_err), 32'd1);
        check("t3_range_rdata", last_rdata, 32'd0);

        // Backpressure with the next request already pending on the bus.
        bp_mode = 1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        wait_valid();
        fork
            begin
                repeat (5) @(posedge clk);
                bp_mode = 0;
            end
            do_req(1'b0, 32'h10, 32'h0, 4'h0);
        join
        check("t4_accept_after_hs", acc_cyc - hs_cyc, 32'd1);
        check("t4_rdata", last_rdata, 32'hDEAD_BEAA);
        wait_idle();

        // Reset during the wait states of a write leaves memory untouched.
        do_req(1'b1, 32'h20, 32'h1122_3344, 4'hF);
        do_req(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        wait_idle();
        check("t5_rdata_after_abort", last_rdata, 32'h1122_3344);

        // LED register address.
        do_req(1'b1, 32'hFFFF_FFF0, 32'h5, 4'h1);
        wait_idle();
`ifdef PSP_MEM_MMIO_LED_EN
        check("t6_wr_err", 32'(last_err), 32'd0);
        check("t6_led", 32'(led), 32'd5);
        do_req(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0);
        wait_idle();
        check("t6_rd_rdata", last_rdata, 32'd5);
`else
        check("t6_wr_err", 32'(last_err), 32'd1);
        check("t6_led", 32'(led), 32'd0);
        do_req(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0);
        wait_idle();
        check("t6_rd_err", 32'(last_err), 32'd1);
`endif

        // Random traffic under random backpressure.
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF);
        bp_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
                6:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                7:       a = 32'(DEPTH * 4 + $urandom_range(0, 63) * 4);
                8:       a = 32'hFFFF_FFF0;
                9:       a = 32'((DEPTH - 1) * 4);
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        bp_mode = 0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psp_mem_responder.md
Name: psp_mem_responder

Overview:
- Responder (target) end of the core's memory interface: accepts one read or write request at a time from the PSP core and returns a response after a programmable number of wait states.
- Backed by an internal word-addressed RAM.
- Sits between the core's memory port and storage, standing in for the system memory that the core initiates against.

Parameters:
ADDR_W, 32, byte address width on the request bus
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
DEPTH_WORDS, 1024, number of 32-bit words in backing RAM
WAIT_STATES, 2, cycles inserted between request accept and response (0..15)

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  write data
req_wmask  input  4  byte-lane write enables
resp_valid  output  1  response available
resp_ready  input  1  core accepts response
resp_rdata  output  DATA_W  read data (0 for writes)
resp_err  output  1  request was out of range or misaligned
led  output  4  MMIO LED register (tied 0 when feature disabled)

Behaviour:
- Reset (reset low, async): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, led=0, wait counter=0. RAM contents are not reset.
- Handshake: request accepted on a cycle where req_valid & req_ready are both high. Response consumed on a cycle where resp_valid & resp_ready are both high.
- Core drive rule: the core holds request fields stable while req_valid is high and req_ready is low.
- Latched at accept: write, addr, wdata, wmask.
- FSM:
  - IDLE: req_ready=1. On accept go to WAIT if WAIT_STATES>0, else EXEC.
  - WAIT: req_ready=0. Counter counts WAIT_STATES cycles, then go to EXEC.
  - EXEC: one cycle; perform RAM read/write; go to RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready. On handshake go to IDLE.
- Latency: with resp_ready held high, resp_valid rises WAIT_STATES+2 cycles after the accept edge (W=0: 2 cycles).
- Throughput: req_ready rises the cycle after the response handshake, so the next request is accepted one cycle after the previous response.
- Address checks:
  - word index = addr[ADDR_W-1:2].
  - Misaligned (addr[1:0]!=0) → resp_err=1, no RAM write, rdata=0.
  - Word index ≥ DEPTH_WORDS → resp_err=1, no RAM write, rdata=0.
- Writes: only bytes with wmask bit set are updated. wmask=0 is a legal no-op write with err=0. resp_rdata=0 on every write response.
- Reads: resp_rdata = full word. wmask is ignored.
- Backpressure: if resp_ready is low, the FSM stays in RESP indefinitely; no new request is accepted.
- Reset mid-transaction: any in-flight request is dropped; no response is issued; a partial write is not performed unless EXEC had already completed.
- Simultaneous events: req_valid asserted during WAIT/EXEC/RESP is ignored (req_ready=0); the request stays pending on the bus.

Optional Feature:
PSP_MEM_MMIO_LED_EN:
- Defined: word address 0xFFFF_FFF0 (full ADDR_W compare) is an MMIO register.
  - Write with wmask[0]=1 → led <= wdata[3:0].
  - Read → rdata = {28'b0, led}.
  - resp_err=0; timing identical to RAM.
- Not defined: led tied to 0; that address follows the normal out-of-range rule (err=1).

Decomposition:
- Shared package psp_mem_pkg:
  - state enum (IDLE, WAIT, EXEC, RESP)
  - MMIO_LED_ADDR constant
  - lane-mask merge function
- Sub-module psp_mem_ram: synchronous single-port RAM with byte enables, 1-cycle read.
- The FSM, checks and MMIO stay in the top.

Test Plan:
1. Reset then read addr 0x0 (W=2) → req_ready=1 after reset; resp_valid 4 cycles after accept; err=0.
2. Write 0xDEADBEEF, mask 4'b1111 to 0x10, then write 0x000000AA, mask 4'b0001 to 0x10, then read 0x10 → rdata=0xDEADBEAA.
3. Read 0x13 → err=1, rdata=0. Read DEPTH_WORDS*4 → err=1, rdata=0.
4. Hold resp_ready=0 for 5 cycles with req_valid held → resp_valid, rdata and err stable; req_ready=0 throughout; accept happens 1 cycle after the response handshake.
5. Assert reset during WAIT of a write to 0x20 → resp_valid never rises; a subsequent read of 0x20 returns the prior value.
6. With PSP_MEM_MMIO_LED_EN: write 0x5 to 0xFFFFFFF0 → led=4'b0101, read returns 0x5. Without the macro: same access → err=1, led=0.
